// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: 1 s prescaler plus 3-digit BCD countdown sequencer
// (start / pause-toggle / abort) with a one-cycle time_up pulse at 000.
module game_timer_ctrl #(
   parameter int TICK_DIV = 50_000_000,
   parameter int DIV_W    = 26
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        abort,
   input  logic [11:0] init_bcd,
   output logic [11:0] bcd,
   output logic        tick,
   output logic        running,
   output logic        paused,
   output logic        time_up,
   output logic        expired
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_PAUSE   = 2'd2;
   localparam logic [1:0] S_EXPIRED = 2'd3;

   localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

   logic [1:0]       state;
   logic [DIV_W-1:0] presc;
   logic [11:0]      load_val;
   logic [11:0]      dec_val;

   function automatic logic [3:0] clamp_d(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // Load value with every digit saturated to 9, and the BCD decrement of bcd.
   always_comb begin
      logic [3:0] d2, d1, d0;
      load_val = {clamp_d(init_bcd[11:8]), clamp_d(init_bcd[7:4]), clamp_d(init_bcd[3:0])};
      d2 = bcd[11:8];
      d1 = bcd[7:4];
      d0 = bcd[3:0];
      if (d0 != 4'd0) begin
         d0 = d0 - 4'd1;
      end else begin
         d0 = 4'd9;
         if (d1 != 4'd0) begin
            d1 = d1 - 4'd1;
         end else begin
            d1 = 4'd9;
            d2 = d2 - 4'd1;
         end
      end
      // 000 is a floor: never wrap to 999.
      dec_val = (bcd == 12'h000) ? 12'h000 : {d2, d1, d0};
   end

   // Main sequencer: reset > abort > start > pause > terminal count.
   always_ff @(posedge clock) begin
      tick    <= 1'b0;
      time_up <= 1'b0;
      if (reset) begin
         state <= S_IDLE;
         bcd   <= 12'h000;
         presc <= '0;
      end else if (abort) begin
         state <= S_IDLE;
         bcd   <= 12'h000;
         presc <= '0;
      end else if (start) begin
         bcd   <= load_val;
         presc <= '0;
         if (load_val == 12'h000) begin
            state   <= S_EXPIRED;
            time_up <= 1'b1;
         end else begin
            state <= S_RUN;
         end
      end else if (pause && (state == S_RUN || state == S_PAUSE)) begin
         // Toggle only; prescaler holds so paused time is neither lost nor gained.
         state <= (state == S_RUN) ? S_PAUSE : S_RUN;
      end else if (state == S_RUN) begin
         if (presc == TERM) begin
            presc <= '0;
            tick  <= 1'b1;
            bcd   <= dec_val;
            if (dec_val == 12'h000) begin
               state   <= S_EXPIRED;
               time_up <= 1'b1;
            end
         end else begin
            presc <= presc + DIV_W'(1);
         end
      end
   end

   assign running = (state == S_RUN);
   assign paused  = (state == S_PAUSE);
   assign expired = (state == S_EXPIRED);

endmodule
